montgomery_exp: RTL and testbench

//   Modular exponentiation controller: result = in_x^in_e mod in_m using left-to-right

---
 rtl/montgomery_exp_if.sv | 22 ++
 rtl/montgomery_exp.sv | 139 +++++++++++++
 tb/tb_montgomery_exp.sv | 261 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/montgomery_exp_if.sv
// montgomery_exp_if: operand bus and start/done handshake between the exponentiation
// controller (master) and the Montgomery multiplier (slave).
interface montgomery_exp_if #(
    parameter int WIDTH = 1024
);
    logic             mont_start;
    logic             mont_done;
    logic [WIDTH-1:0] mont_a;
    logic [WIDTH-1:0] mont_b;
    logic [WIDTH-1:0] mont_m;
    logic [WIDTH-1:0] mont_result;

    modport master (
        output mont_start, mont_a, mont_b, mont_m,
        input  mont_result, mont_done
    );

    modport slave (
        input  mont_start, mont_a, mont_b, mont_m,
        output mont_result, mont_done
    );
endinterface

// File: rtl/montgomery_exp.sv
// montgomery_exp: x^e mod m by left-to-right square-and-multiply, all operands held in
// the Montgomery domain and every product delegated to an external Montgomery multiplier.
module montgomery_exp #(
    parameter int WIDTH      = 1024,
    parameter int EXP_WIDTH  = 1024,
    parameter bit CONST_TIME = 1'b0
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 start,
    input  logic [WIDTH-1:0]     in_x,
    input  logic [EXP_WIDTH-1:0] in_e,
    input  logic [WIDTH-1:0]     in_m,
    input  logic [WIDTH-1:0]     in_r,
    input  logic [WIDTH-1:0]     in_r2,
    output logic [WIDTH-1:0]     result,
    output logic                 done,
    output logic                 busy,
    montgomery_exp_if.master     mbus
);
    localparam int IW = EXP_WIDTH > 1 ? $clog2(EXP_WIDTH) : 1;

    typedef enum logic [2:0] {IDLE, TOMONT, SQUARE, MULT, NEXT, FROMONT, DONE} state_t;

    state_t               state_q, state_d;
    logic [WIDTH-1:0]     x_q, x_d, m_q, m_d, a_q, a_d, result_q, result_d;
    logic [WIDTH-1:0]     mont_a_q, mont_a_d, mont_b_q, mont_b_d;
    logic [EXP_WIDTH-1:0] e_q, e_d;
    logic [IW-1:0]        idx_q, idx_d;
    logic                 done_q, done_d, busy_q, busy_d, mont_start_q, mont_start_d;
    logic                 fin, bit_set;

    // A done arriving alongside our own start pulse belongs to no multiply of ours.
    assign fin     = mbus.mont_done & ~mont_start_q;
    assign bit_set = e_q[idx_q];

    // Every multiply is launched on the transition into its state, so mont_start is
    // high exactly in that state's entry cycle.
    always_comb begin
        state_d      = state_q;
        x_d          = x_q;
        e_d          = e_q;
        m_d          = m_q;
        a_d          = a_q;
        idx_d        = idx_q;
        result_d     = result_q;
        busy_d       = busy_q;
        mont_a_d     = mont_a_q;
        mont_b_d     = mont_b_q;
        mont_start_d = 1'b0;
        done_d       = 1'b0;
        case (state_q)
            IDLE: if (start) begin
                x_d          = in_x;
                e_d          = in_e;
                m_d          = in_m;
                a_d          = in_r;
                idx_d        = IW'(EXP_WIDTH - 1);
                busy_d       = 1'b1;
                mont_start_d = 1'b1;
                mont_a_d     = in_x;
                mont_b_d     = in_r2;
                state_d      = TOMONT;
            end
            TOMONT: if (fin) begin
                x_d          = mbus.mont_result;
                mont_start_d = 1'b1;
                mont_a_d     = a_q;
                mont_b_d     = a_q;
                state_d      = SQUARE;
            end
            SQUARE: if (fin) begin
                a_d          = mbus.mont_result;
                mont_start_d = bit_set | CONST_TIME;
                mont_a_d     = mbus.mont_result;
                mont_b_d     = x_q;
                state_d      = (bit_set | CONST_TIME) ? MULT : NEXT;
            end
            MULT: if (fin) begin
                a_d     = bit_set ? mbus.mont_result : a_q;
                state_d = NEXT;
            end
            NEXT: begin
                mont_start_d = 1'b1;
                mont_a_d     = a_q;
                mont_b_d     = idx_q == '0 ? WIDTH'(1) : a_q;
                idx_d        = idx_q == '0 ? idx_q : idx_q - 1'b1;
                state_d      = idx_q == '0 ? FROMONT : SQUARE;
            end
            FROMONT: if (fin) begin
                a_d      = mbus.mont_result;
                result_d = mbus.mont_result;
                done_d   = 1'b1;
                busy_d   = 1'b0;
                state_d  = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q      <= IDLE;
            x_q          <= '0;
            e_q          <= '0;
            m_q          <= '0;
            a_q          <= '0;
            idx_q        <= '0;
            result_q     <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            mont_start_q <= 1'b0;
            mont_a_q     <= '0;
            mont_b_q     <= '0;
        end else begin
            state_q      <= state_d;
            x_q          <= x_d;
            e_q          <= e_d;
            m_q          <= m_d;
            a_q          <= a_d;
            idx_q        <= idx_d;
            result_q     <= result_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            mont_start_q <= mont_start_d;
            mont_a_q     <= mont_a_d;
            mont_b_q     <= mont_b_d;
        end
    end

    assign result          = result_q;
    assign done            = done_q;
    assign busy            = busy_q;
    assign mbus.mont_start = mont_start_q;
    assign mbus.mont_a     = mont_a_q;
    assign mbus.mont_b     = mont_b_q;
    assign mbus.mont_m     = m_q;
endmodule

// File: tb/tb_montgomery_exp.sv
// tb_montgomery_exp: directed and random exponentiation runs against three controller
// configurations, each paired with a behavioural 5-cycle Montgomery multiplier.
module tb_montgomery_exp;
    localparam int W = 1024;
    localparam int L = 5;

    typedef struct {
        int           g;
        logic [W-1:0] x, e, m, res;
        int           nmul;
    } vec_t;

    logic         clk = 1'b0;
    logic         resetn = 1'b0;
    logic         start_i [3];
    logic [W-1:0] result_o [3];
    logic         done_o [3];
    logic         busy_o [3];
    logic [W-1:0] in_x = '0, in_e = '0, in_m = '0, in_r = '0, in_r2 = '0;
    int           nvec = 0, nfail = 0;

    always #5 clk = ~clk;

    // a*b*R^-1 mod m via REDC; -m^-1 mod R comes from Newton iteration on the odd modulus.
    function automatic logic [W-1:0] mont(input logic [W-1:0] a, b, m);
        logic [W-1:0]   inv, u;
        logic [2*W-1:0] t;
        logic [2*W:0]   s;
        inv = m;
        for (int k = 0; k < 10; k++) inv = inv * (W'(2) - m * inv);
        t = {{W{1'b0}}, a} * {{W{1'b0}}, b};
        u = t[W-1:0] * (~inv + 1'b1);
        s = {1'b0, t} + {{(W+1){1'b0}}, u} * {{(W+1){1'b0}}, m};
        s = s >> W;
        return (s[W:0] >= {1'b0, m}) ? W'(s[W:0] - {1'b0, m}) : s[W-1:0];
    endfunction

    function automatic logic [W-1:0] modexp(input logic [W-1:0] x, e, m, input int ew);
        logic [2*W-1:0] acc, xx, mm;
        acc = 1;
        xx  = {{W{1'b0}}, x};
        mm  = {{W{1'b0}}, m};
        for (int k = ew - 1; k >= 0; k--) begin
            acc = (acc * acc) % mm;
            if (e[k]) acc = (acc * xx) % mm;
        end
        return acc[W-1:0];
    endfunction

    function automatic logic [W-1:0] rmod(input logic [W-1:0] m);
        logic [2*W-1:0] big;
        big    = '0;
        big[W] = 1'b1;
        return W'(big % {{W{1'b0}}, m});
    endfunction

    function automatic logic [W-1:0] r2mod(input logic [W-1:0] m);
        logic [2*W-1:0] r;
        r = {{W{1'b0}}, rmod(m)};
        return W'((r * r) % {{W{1'b0}}, m});
    endfunction

    for (genvar g = 0; g < 3; g++) begin : gk
        localparam int EW = g == 2 ? 32 : 1024;
        localparam bit CT = g == 1;
        int           nstart = 0;
        int           cnt = 0;
        bit           bad = 1'b0;
        logic [W-1:0] ca, cb, cm;
        montgomery_exp_if #(.WIDTH(W)) mif ();
        montgomery_exp #(.WIDTH(W), .EXP_WIDTH(EW), .CONST_TIME(CT)) dut (
            .clk(clk), .resetn(resetn), .start(start_i[g]),
            .in_x(in_x), .in_e(in_e[EW-1:0]), .in_m(in_m), .in_r(in_r), .in_r2(in_r2),
            .result(result_o[g]), .done(done_o[g]), .busy(busy_o[g]), .mbus(mif)
        );
        always @(posedge clk or negedge resetn) begin
            if (!resetn) begin
                cnt              <= 0;
                mif.mont_done    <= 1'b0;
                mif.mont_result  <= '0;
            end else begin
                mif.mont_done <= 1'b0;
                if (mif.mont_start) begin
                    nstart <= nstart + 1;
                    cnt    <= L;
                    ca     <= mif.mont_a;
                    cb     <= mif.mont_b;
                    cm     <= mif.mont_m;
                end else if (cnt > 0) begin
                    if (mif.mont_a !== ca || mif.mont_b !== cb || mif.mont_m !== cm) bad <= 1'b1;
                    if (cnt == 1) begin
                        mif.mont_done   <= 1'b1;
                        mif.mont_result <= mont(ca, cb, cm);
                    end
                    cnt <= cnt - 1;
                end
            end
        end
    end

    function automatic int get_nstart(input int g);
        case (g)
            0:       return gk[0].nstart;
            1:       return gk[1].nstart;
            default: return gk[2].nstart;
        endcase
    endfunction

    function automatic int get_bad(input int g);
        case (g)
            0:       return int'(gk[0].bad);
            1:       return int'(gk[1].bad);
            default: return int'(gk[2].bad);
        endcase
    endfunction

    function automatic int get_mstart(input int g);
        case (g)
            0:       return int'(gk[0].mif.mont_start);
            1:       return int'(gk[1].mif.mont_start);
            default: return int'(gk[2].mif.mont_start);
        endcase
    endfunction

    task automatic check(input string nm, input logic [W-1:0] act, exp);
        nvec++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got 0x%0h want 0x%0h (low 128 bits)", nm, act[127:0], exp[127:0]);
        end
    endtask

    task automatic check_i(input string nm, input int act, exp);
        nvec++;
        if (act != exp) begin
            nfail++;
            $display("FAIL %s: got %0d want %0d", nm, act, exp);
        end
    endtask

    task automatic start_run(input int g, input logic [W-1:0] x, e, m);
        in_x  = x;
        in_e  = e;
        in_m  = m;
        in_r  = rmod(m);
        in_r2 = r2mod(m);
        @(negedge clk);
        start_i[g] = 1'b1;
        @(negedge clk);
        start_i[g] = 1'b0;
    endtask

    task automatic finish_run(input int g, output logic [W-1:0] res, output int ndone, output int cyc);
        int limit;
        limit = g == 2 ? 2000 : 20000;
        ndone = 0;
        cyc   = 0;
        while (ndone == 0 && cyc < limit) begin
            @(negedge clk);
            cyc++;
            if (done_o[g]) ndone++;
        end
        res = result_o[g];
        repeat (4) begin
            @(negedge clk);
            if (done_o[g]) ndone++;
        end
        check_i("busy low after done", int'(busy_o[g]), 0);
    endtask

    initial begin
        vec_t         vt [6];
        int           cyc_v [6];
        int           s0, nd, cyc;
        logic [W-1:0] res;

        for (int g = 0; g < 3; g++) start_i[g] = 1'b0;
        vt[0] = '{g:0, x:W'(3),          e:W'(5), m:W'(7),          res:W'(5),          nmul:1028};
        vt[1] = '{g:1, x:W'(3),          e:W'(5), m:W'(7),          res:W'(5),          nmul:2050};
        vt[2] = '{g:1, x:W'(3),          e:W'(1), m:W'(7),          res:W'(3),          nmul:2050};
        vt[3] = '{g:2, x:W'(16'h1234),   e:W'(0), m:W'(16'hFFF1),   res:W'(1),          nmul:34};
        vt[4] = '{g:2, x:W'(16'h1234),   e:W'(1), m:W'(16'hFFF1),   res:W'(16'h1234),   nmul:35};
        vt[5] = '{g:2, x:W'(3),          e:W'(5), m:W'(7),          res:W'(5),          nmul:36};

        repeat (3) @(negedge clk);
        for (int g = 0; g < 3; g++) begin
            check("reset result", result_o[g], '0);
            check_i("reset busy", int'(busy_o[g]), 0);
            check_i("reset done", int'(done_o[g]), 0);
            check_i("reset mont_start", get_mstart(g), 0);
        end
        resetn = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 6; i++) begin
            s0 = get_nstart(vt[i].g);
            start_run(vt[i].g, vt[i].x, vt[i].e, vt[i].m);
            finish_run(vt[i].g, res, nd, cyc);
            cyc_v[i] = cyc;
            check($sformatf("vec%0d result", i), res, vt[i].res);
            check_i($sformatf("vec%0d done pulses", i), nd, 1);
            check_i($sformatf("vec%0d mont_start count", i), get_nstart(vt[i].g) - s0, vt[i].nmul);
        end
        check_i("const-time latency e=5 vs e=1", cyc_v[1], cyc_v[2]);

        // Second start mid-run must be ignored.
        s0 = get_nstart(2);
        start_run(2, W'(16'h1234), W'(32'hB7), W'(16'hFFF1));
        repeat (40) @(negedge clk);
        in_x = W'(5);
        in_e = W'(3);
        in_m = W'(11);
        start_i[2] = 1'b1;
        @(negedge clk);
        start_i[2] = 1'b0;
        check_i("busy held through re-start", int'(busy_o[2]), 1);
        finish_run(2, res, nd, cyc);
        check("re-start result", res, modexp(W'(16'h1234), W'(32'hB7), W'(16'hFFF1), 32));
        check_i("re-start done pulses", nd, 1);
        check_i("re-start mont_start count", get_nstart(2) - s0, 40);

        // One-cycle reset while the first square is in flight.
        start_run(2, W'(16'h1234), W'(32'hFFFFFFFF), W'(16'hFFF1));
        repeat (8) @(negedge clk);
        resetn = 1'b0;
        #1;
        check_i("abort busy", int'(busy_o[2]), 0);
        check_i("abort done", int'(done_o[2]), 0);
        check_i("abort mont_start", get_mstart(2), 0);
        check("abort result", result_o[2], '0);
        @(negedge clk);
        resetn = 1'b1;
        start_run(2, W'(16'h0BEE), W'(32'h0001_0003), W'(16'hFFF1));
        finish_run(2, res, nd, cyc);
        check("post-abort result", res, modexp(W'(16'h0BEE), W'(32'h0001_0003), W'(16'hFFF1), 32));
        check_i("post-abort done pulses", nd, 1);

        for (int n = 0; n < 20; n++) begin
            logic [W-1:0] m, x, e;
            for (int k = 0; k < W / 32; k++) begin
                m[k*32 +: 32] = $urandom;
                x[k*32 +: 32] = $urandom;
            end
            m[0]     = 1'b1;
            m[W-1]   = 1'b1;
            x        = x % m;
            e        = '0;
            e[31:0]  = $urandom;
            s0 = get_nstart(2);
            start_run(2, x, e, m);
            finish_run(2, res, nd, cyc);
            check($sformatf("random%0d result", n), res, modexp(x, e, m, 32));
            check_i($sformatf("random%0d mont_start count", n), get_nstart(2) - s0, 34 + $countones(e));
        end

        for (int g = 0; g < 3; g++) check_i($sformatf("operands stable dut%0d", g), get_bad(g), 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end
endmodule
